// File: rtl/vga_sync_decoder_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vga_sync_decoder_if                                                       |
// | Sync inputs and recovered timing/coordinate outputs of vga_sync_decoder.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface vga_sync_decoder_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        locked;
  logic        line_start;
  logic        frame_start;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        visible;
  logic [11:0] h_period;
  logic [10:0] v_lines;

  modport master (
    output hsync_in, vsync_in,
    input  locked, line_start, frame_start, x, y, visible, h_period, v_lines
  );

  modport slave (
    input  hsync_in, vsync_in,
    output locked, line_start, frame_start, x, y, visible, h_period, v_lines
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vga_sync_decoder                                                          |
// | Locks to an incoming hsync/vsync stream and recovers pixel coordinates.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_BACK      = 144,
  parameter int V_BACK      = 35,
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int H_TOL       = 0,
  parameter int LOCK_FRAMES = 2,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0
) (
  input wire                dot_clk,
  input wire                reset_n,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [12:0] c_h_total = 13'(H_TOTAL);
  localparam logic [12:0] c_h_tol   = 13'(H_TOL);
  localparam logic [11:0] c_v_total = 12'(V_TOTAL);
  localparam logic [11:0] c_h_back  = 12'(H_BACK);
  localparam logic [11:0] c_h_end   = 12'(H_BACK + H_VISIBLE);
  localparam logic [10:0] c_v_back  = 11'(V_BACK);
  localparam logic [10:0] c_v_end   = 11'(V_BACK + V_VISIBLE);
  localparam logic [7:0]  c_lock    = 8'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  // [0] metastability flop, [1] synchronised level, [2] previous level
  logic [2:0]  hs_pipe_q, vs_pipe_q;
  logic [11:0] h_count_q, h_period_q;
  logic [10:0] v_count_q, v_lines_q;
  logic        vs_pend_q, frame_ok_q;
  logic        line_start_q, frame_start_q, visible_q;
  logic [9:0]  x_q, y_q;

  logic        w_hs_lead, w_vs_lead, w_boundary;
  logic        w_h_sat, w_v_sat, w_line_ok, w_frame_good, w_in_win;
  logic [12:0] w_h_len;
  logic [11:0] w_v_len;
  logic [7:0]  w_good_inc;

  assign w_hs_lead = (hs_pipe_q[1] == HSYNC_POL) && (hs_pipe_q[2] != HSYNC_POL);
  assign w_vs_lead = (vs_pipe_q[1] == VSYNC_POL) && (vs_pipe_q[2] != VSYNC_POL);
  // A vsync edge is held pending until the line it falls in ends.
  assign w_boundary = w_hs_lead && (vs_pend_q || w_vs_lead);

  assign w_h_sat = &h_count_q;
  assign w_v_sat = &v_count_q;
  assign w_h_len = {1'b0, h_count_q} + 13'd1;
  assign w_v_len = {1'b0, v_count_q} + 12'd1;
  assign w_line_ok = (w_h_len >= c_h_total) ? ((w_h_len - c_h_total) <= c_h_tol)
                                            : ((c_h_total - w_h_len) <= c_h_tol);
  assign w_frame_good = frame_ok_q && (w_v_len == c_v_total);
  assign w_good_inc   = good_cnt_q + 8'd1;
  assign w_in_win = (state_q == ST_LOCKED) &&
                    (h_count_q >= c_h_back) && (h_count_q < c_h_end) &&
                    (v_count_q >= c_v_back) && (v_count_q < c_v_end);

  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (w_boundary) begin
          state_d    = ST_MEASURE;
          good_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (w_h_sat) begin
          state_d = ST_SEARCH;
        end else if (w_boundary) begin
          if (w_frame_good) begin
            good_cnt_d = w_good_inc;
            if (w_good_inc == c_lock) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_h_sat || (w_hs_lead && !w_line_ok) || (w_boundary && !w_frame_good))
          state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      h_count_q     <= '0;
      h_period_q    <= '0;
      v_count_q     <= '0;
      v_lines_q     <= '0;
      vs_pend_q     <= 1'b0;
      frame_ok_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      visible_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      hs_pipe_q <= {hs_pipe_q[1:0], bus.hsync_in};
      vs_pipe_q <= {vs_pipe_q[1:0], bus.vsync_in};

      if (w_hs_lead)     h_count_q <= '0;
      else if (!w_h_sat) h_count_q <= h_count_q + 12'd1;
      if (w_hs_lead)     h_period_q <= w_h_sat ? h_count_q : w_h_len[11:0];

      if (w_boundary) begin
        v_lines_q <= w_v_sat ? v_count_q : w_v_len[10:0];
        v_count_q <= '0;
      end else if (w_hs_lead && !w_v_sat) begin
        v_count_q <= v_count_q + 11'd1;
      end

      vs_pend_q <= w_hs_lead ? 1'b0 : (vs_pend_q | w_vs_lead);

      if (w_boundary)                   frame_ok_q <= 1'b1;
      else if (w_hs_lead && !w_line_ok) frame_ok_q <= 1'b0;

      line_start_q  <= w_hs_lead;
      frame_start_q <= w_boundary;
      visible_q     <= w_in_win;
      x_q           <= w_in_win ? 10'(h_count_q - c_h_back) : '0;
      y_q           <= w_in_win ? 10'(v_count_q - c_v_back) : '0;
    end
  end

  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.visible     = visible_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.h_period    = h_period_q;
  assign bus.v_lines     = v_lines_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_vga_sync_decoder                                                       |
// | Two decoders (H_TOL 0 and 1) on a scaled 40x12 mode, model-checked.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_vga_sync_decoder;
  localparam int HT = 40, VT = 12, HB = 8, VB = 3, HV = 24, VV = 6, LF = 2;
  localparam int HSW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hs = 1'b1, vs = 1'b1;
  int   errors = 0, checks = 0, shown = 0;

  always #5 clk = ~clk;

  vga_sync_decoder_if bus0 ();
  vga_sync_decoder_if bus1 ();
  assign bus0.hsync_in = hs;
  assign bus0.vsync_in = vs;
  assign bus1.hsync_in = hs;
  assign bus1.vsync_in = vs;

  vga_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_BACK(HB), .V_BACK(VB),
    .H_VISIBLE(HV), .V_VISIBLE(VV), .H_TOL(0), .LOCK_FRAMES(LF),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0))
    dut0 (.dot_clk(clk), .reset_n(reset_n), .bus(bus0));

  vga_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_BACK(HB), .V_BACK(VB),
    .H_VISIBLE(HV), .V_VISIBLE(VV), .H_TOL(1), .LOCK_FRAMES(LF),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0))
    dut1 (.dot_clk(clk), .reset_n(reset_n), .bus(bus1));

  // Reference model: syncs seen through a three-sample delay line, line length
  // as time since the last hsync leading edge, lines counted per frame.
  int n = 0, anchor = 0;
  bit p1h, p2h, p3h, p1v, p2v, p3v;
  int vc = 0, hper = 0, vlines = 0;
  bit vpend, m_ls, m_fs;
  int st[2], good[2], ex[2], ey[2], tol[2];
  bit fok[2], vis[2];
  int hc_o, vc_o, hlen;
  bit hl, vl, bnd, lok, fgood, wdog;

  initial begin
    tol[0] = 0;
    tol[1] = 1;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anchor = n;
      {p1h, p2h, p3h, p1v, p2v, p3v} = '0;
      vc = 0; hper = 0; vlines = 0; vpend = 0; m_ls = 0; m_fs = 0;
      for (int i = 0; i < 2; i++) begin
        st[i] = 0; good[i] = 0; fok[i] = 0; vis[i] = 0; ex[i] = 0; ey[i] = 0;
      end
    end else begin
      n = n + 1;
      hc_o = n - 1 - anchor;
      if (hc_o > 4095) hc_o = 4095;
      vc_o = vc;
      hl   = !p2h && p3h;
      vl   = !p2v && p3v;
      bnd  = hl && (vpend || vl);
      hlen = hc_o + 1;
      wdog = (hc_o == 4095);
      for (int i = 0; i < 2; i++) begin
        lok   = (hlen - HT <= tol[i]) && (HT - hlen <= tol[i]);
        fgood = fok[i] && (vc_o + 1 == VT);
        vis[i] = (st[i] == 2) && hc_o >= HB && hc_o < HB + HV && vc_o >= VB && vc_o < VB + VV;
        ex[i]  = vis[i] ? hc_o - HB : 0;
        ey[i]  = vis[i] ? vc_o - VB : 0;
        if (st[i] == 0) begin
          if (bnd) begin st[i] = 1; good[i] = 0; end
        end else if (st[i] == 1) begin
          if (wdog) st[i] = 0;
          else if (bnd) begin
            if (fgood) begin
              good[i] = good[i] + 1;
              if (good[i] == LF) st[i] = 2;
            end else good[i] = 0;
          end
        end else if (wdog || (hl && !lok) || (bnd && !fgood)) begin
          st[i] = 0;
        end
        if (bnd) fok[i] = 1;
        else if (hl && !lok) fok[i] = 0;
      end
      if (hl) hper = (hlen > 4095) ? 4095 : hlen;
      if (bnd) begin
        vlines = (vc_o + 1 > 2047) ? 2047 : vc_o + 1;
        vc = 0;
      end else if (hl && vc < 2047) vc = vc + 1;
      vpend = hl ? 1'b0 : (vpend | vl);
      m_ls = hl;
      m_fs = bnd;
      if (hl) anchor = n;
      p3h = p2h; p2h = p1h; p1h = hs;
      p3v = p2v; p2v = p1v; p1v = vs;
    end
  end

  function automatic logic [46:0] pack_exp(input int i);
    return {st[i] == 2, m_ls, m_fs, vis[i], 10'(ex[i]), 10'(ey[i]), 12'(hper), 11'(vlines)};
  endfunction

  always @(negedge clk) begin
    logic [46:0] got [2];
    got[0] = {bus0.locked, bus0.line_start, bus0.frame_start, bus0.visible,
              bus0.x, bus0.y, bus0.h_period, bus0.v_lines};
    got[1] = {bus1.locked, bus1.line_start, bus1.frame_start, bus1.visible,
              bus1.x, bus1.y, bus1.h_period, bus1.v_lines};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== pack_exp(i)) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL model dut%0d t=%0t {lk,ls,fs,vis,x,y,hper,vl} got=%h want=%h",
                   i, $time, got[i], pack_exp(i));
        end
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic drive(input bit h, input bit v);
    @(posedge clk);
    #2;
    hs = h;
    vs = v;
  endtask

  task automatic send_frame(input int htot, input int lines, input int voff);
    for (int l = 0; l < lines; l++)
      for (int d = 0; d < htot; d++) begin
        int pos;
        pos = l * htot + d;
        drive(d >= HSW, !(pos >= voff && pos < voff + 2 * htot));
      end
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) drive(1'b1, 1'b1);
  endtask

  task automatic wait_fs(input int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus0.frame_start && k < lim);
    if (!bus0.frame_start) chk("frame_start_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_dut0"}, {bus0.locked, bus0.line_start, bus0.frame_start, bus0.visible,
                        bus0.x, bus0.y, bus0.h_period, bus0.v_lines}, 0);
    chk({nm, "_dut1"}, {bus1.locked, bus1.line_start, bus1.frame_start, bus1.visible,
                        bus1.x, bus1.y, bus1.h_period, bus1.v_lines}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk);
    #2 reset_n = 1'b1;
    idle(10);

    // Nominal mode: latency, coincident edges, lock timing, visible window
    fork
      repeat (4) send_frame(HT, VT, 0);
      begin
        int k, vcnt, fx, fy, lx, ly;
        bit pv;
        k = 0;
        while (hs && k < 100) begin @(negedge clk); k++; end
        chk("hs_seen", hs, 0);
        repeat (2) @(negedge clk);
        chk("line_start_early", bus0.line_start, 0);
        @(negedge clk);
        chk("line_start_latency3", bus0.line_start, 1);
        chk("frame_start_coincident", bus0.frame_start, 1);
        chk("locked_fs1", bus0.locked, 0);
        wait_fs(2000);
        chk("locked_fs2", bus0.locked, 0);
        wait_fs(2000);
        chk("locked_fs3", bus0.locked, 1);
        chk("locked_fs3_tol1", bus1.locked, 1);
        vcnt = 0; fx = -1; fy = -1; lx = -1; ly = -1; pv = 0; k = 0;
        do begin
          @(negedge clk);
          k++;
          if (bus0.visible) begin
            if (vcnt == 0) begin fx = bus0.x; fy = bus0.y; end
            lx = bus0.x; ly = bus0.y; vcnt++;
          end else if (pv) begin
            chk("after_visible_xy", {bus0.x, bus0.y}, 0);
          end
          pv = bus0.visible;
        end while (!bus0.frame_start && k < 2000);
        chk("visible_count", vcnt, HV * VV);
        chk("first_visible_x", fx, 0);
        chk("first_visible_y", fy, 0);
        chk("last_visible_x", lx, HV - 1);
        chk("last_visible_y", ly, VV - 1);
      end
    join
    chk("h_period_nominal", bus0.h_period, HT);
    chk("v_lines_nominal", bus0.v_lines, VT);

    // Line period one dot long
    repeat (4) send_frame(HT + 1, VT, 0);
    chk("long_line_unlocked_tol0", bus0.locked, 0);
    chk("long_line_h_period", bus0.h_period, HT + 1);
    chk("long_line_locked_tol1", bus1.locked, 1);

    // Relock, then hsync stops until the watchdog fires
    repeat (3) send_frame(HT, VT, 0);
    chk("relock_tol0", bus0.locked, 1);
    idle(4200);
    chk("watchdog_unlock0", bus0.locked, 0);
    chk("watchdog_unlock1", bus1.locked, 0);
    fork
      send_frame(HT, VT, 0);
      begin
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus0.line_start && k < 200);
        chk("h_period_saturated", bus0.h_period, 4095);
      end
    join

    // Short frame drops lock at its closing boundary
    repeat (2) send_frame(HT, VT, 0);
    chk("locked_before_short", bus0.locked, 1);
    fork
      begin
        send_frame(HT, VT - 1, 0);
        repeat (4) send_frame(HT, VT, 0);
      end
      begin
        wait_fs(2000);
        chk("short_start_locked", bus0.locked, 1);
        wait_fs(2000);
        chk("short_end_unlocked", bus0.locked, 0);
        chk("short_v_lines", bus0.v_lines, VT - 1);
      end
    join
    chk("relock_after_short", bus0.locked, 1);

    // Reset pulse mid-frame
    fork
      send_frame(HT, VT, 0);
      begin
        repeat (200) @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midframe_reset");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
      end
    join

    // Randomized timing variations, including mid-line vsync
    repeat (12) begin
      case ($urandom_range(0, 3))
        0: idle($urandom_range(1, 30));
        default: ;
      endcase
      send_frame($urandom_range(HT - 1, HT + 1), $urandom_range(VT - 1, VT + 1),
                 $urandom_range(0, 2) * 17);
    end
    repeat (3) send_frame(HT, VT, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
